// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer
//   Multi-cycle wide adder: computes {cout,sum} = x + y + cin one SLICE-bit
//   carry-lookahead slice per clock, LSB slice first, with a registered
//   inter-slice carry. Operands are latched on an in_valid/in_ready handshake
//   and the result is presented on an out_valid/out_ready handshake.
//
// Parameters
//   WIDTH  operand/sum width (integer multiple of SLICE)
//   SLICE  bits computed per cycle (>= 1)
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   x, y, cin           operands and carry-in
//   out_valid,out_ready result handshake
//   sum, cout           registered result
//   busy                high in RUN or DONE
//   ovf                 signed overflow flag (only with CLA_SEQ_OVF_FLAG_EN)
//   slice_idx           slice currently being computed (debug)
//
// Optional feature macro: CLA_SEQ_OVF_FLAG_EN adds the registered ovf output.
module cla_slice_sequencer #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3,
  localparam int NS = WIDTH / SLICE,
  localparam int IW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
`ifdef CLA_SEQ_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic [IW-1:0]    slice_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] xr, yr;
  logic             carry;

  logic [SLICE-1:0] a, b, g, p, s;
  logic [SLICE:0]   c;

  // Lookahead slice: every carry is a flat sum of products of the slice
  // generate/propagate terms and the slice carry-in, not a ripple.
  always_comb begin
    logic acc, term;
    a = SLICE'(xr >> (slice_idx * SLICE));
    b = SLICE'(yr >> (slice_idx * SLICE));
    g = a & b;
    p = a | b;
    c = '0;
    c[0] = carry;
    for (int unsigned i = 0; i < SLICE; i++) begin
      acc = carry;
      for (int unsigned m = 0; m <= i; m++) acc = acc & p[m];
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    s = a ^ b ^ c[SLICE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      slice_idx <= '0;
      carry     <= 1'b0;
      xr        <= '0;
      yr        <= '0;
`ifdef CLA_SEQ_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr        <= x;
            yr        <= y;
            carry     <= cin;
            slice_idx <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
`ifdef CLA_SEQ_OVF_FLAG_EN
            ovf       <= 1'b0;
`endif
            state     <= RUN;
          end
        end
        RUN: begin
          sum[slice_idx*SLICE +: SLICE] <= s;
          carry <= c[SLICE];
          if (slice_idx == IW'(NS - 1)) begin
            cout      <= c[SLICE];
`ifdef CLA_SEQ_OVF_FLAG_EN
            ovf       <= c[SLICE-1] ^ c[SLICE];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            slice_idx <= slice_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
- Multi-cycle wide adder controller that computes a WIDTH-bit sum one SLICE-bit carry-lookahead slice per clock.
- Serves datapaths that must add operands wider than the single-cycle lookahead slice.
- Latches the operands on a valid/ready handshake, walks the slices LSB-first with a registered inter-slice carry, and presents the result on a valid/ready output handshake.

Parameters:
- WIDTH, 12, operand and sum width in bits; must be an integer multiple of SLICE.
- SLICE, 3, bits computed per cycle by the internal lookahead slice; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands and carry-in are valid.
- in_ready  output  1  block accepts new operands (IDLE only).
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.
- slice_idx  output  clog2(WIDTH/SLICE), minimum 1  index of the slice being computed; debug only.

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk rising edge forces the following.
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0; cout=0; slice_idx=0; internal carry register=0; operand registers=0.
- Reset mid-operation aborts the operation; the partial result is discarded.
- Let NS = WIDTH/SLICE.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - on in_valid&in_ready: latch x, y, and cin into the carry register; clear slice_idx and sum; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle computes slice k=slice_idx over bits [k*SLICE +: SLICE].
  - Per bit: g=a&b, p=a|b.
  - Carry into bit i of the slice: c(i+1) = g(i) | p(i)&c(i), fully expanded as a lookahead sum of products from the slice carry-in. No ripple chain of registers.
  - Sum bit = (a^b)^c(i).
  - The slice sum is written into sum[k*SLICE +: SLICE]; the slice carry-out goes to the carry register.
  - If k==NS-1: cout takes the slice carry-out; go to DONE. Otherwise slice_idx increments.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - on out_ready: out_valid drops at the next edge; go to IDLE.
  - in_ready stays 0 during DONE, so there is no accept in the same cycle as the result handoff.
- Latency: out_valid rises exactly NS clock edges after the accepting edge. With defaults: 4 edges.
- Throughput: one operation per NS+2 cycles minimum, counting the IDLE cycle.
- Arithmetic: unsigned modulo 2^WIDTH. {cout,sum} = x+y+cin exactly.
- x, y and cin changing while not in IDLE have no effect.
- out_ready asserted while out_valid=0 is ignored.
- in_valid deasserted before acceptance is legal; there is no latching without the handshake.
- NS==1 (SLICE==WIDTH): RUN lasts one cycle; the single-cycle lookahead add is preserved.
- slice_idx wraps to 0 only via a new accept, never by increment past NS-1.

Optional Feature:
- Macro: CLA_SEQ_OVF_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit), the registered signed two's-complement overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ovf is captured in the final RUN cycle and held through DONE.
  - ovf is reset to 0 and cleared on accept.
- When undefined:
  - Port ovf is absent; no extra logic.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: assert rst 2 cycles, release → in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- Full carry chain: x=0xFFF, y=0x001, cin=0 → after 4 edges: out_valid=1, sum=0x000, cout=1.
  - With the macro defined: ovf=0.
- Carry-in propagation: x=0x7FF, y=0x000, cin=1 → sum=0x800, cout=0.
  - With the macro defined: ovf=1.
- Back-pressure: x=0x123, y=0x456, cin=0, out_ready held 0 for 5 cycles → sum=0x579, cout=0 held stable with out_valid=1 throughout; in_ready=0; then out_ready=1 → next cycle out_valid=0, in_ready=1.
- Reset mid-operation: accept x=0xABC, y=0x111; assert rst at slice_idx=2 → next cycle state IDLE, sum=0, out_valid=0.
  - Then a new add x=0x005, y=0x003 yields sum=0x008.
- Random sweep with in_valid toggling and out_ready random: 1000 operations, each {cout,sum} matches x+y+cin; every accept is followed by out_valid exactly 4 edges later.
